// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU retirement trace buffer: FSM states, capture modes,
// trace entry layout and the capture-selection helper.
package cpu_trace_pkg;

   localparam int unsigned TRACE_XLEN = 32;

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_ALL    = 2'd1;
   localparam logic [1:0] MODE_STORES = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } trace_state_t;

   typedef struct packed {
      logic [TRACE_XLEN-1:0] pc;
      logic [TRACE_XLEN-1:0] instr;
      logic [TRACE_XLEN-1:0] adr;
      logic [TRACE_XLEN-1:0] wdata;
      logic                  memwrite;
   } trace_entry_t;

   // Mode 3 (and MODE_OFF) select nothing.
   function automatic logic mode_selects(input logic [1:0] m, input logic mw);
      return (m == MODE_ALL) || ((m == MODE_STORES) && mw);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace FIFO with overwrite-on-full and a registered head entry
// that holds its last value when the FIFO drains.
module trace_fifo
   import cpu_trace_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter type         entry_t = trace_entry_t
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  entry_t                   din,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output entry_t                   rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wptr, rptr, wptr_n, rptr_n;
   logic [CW-1:0]   count_n;
   logic            pop, full, drop, wr_en;
   entry_t          head_n;

   always_comb begin
      pop     = rd_valid & rd_ready;
      full    = (count == CW'(DEPTH));
      wr_en   = push & ~flush;
      drop    = wr_en & full & ~pop;
      wptr_n  = wr_en ? wptr + PW'(1) : wptr;
      rptr_n  = (pop | drop) ? rptr + PW'(1) : rptr;
      count_n = count;
      if (wr_en && !pop && !full)
         count_n = count + CW'(1);
      else if (pop && !wr_en)
         count_n = count - CW'(1);
      // The entry being written this cycle becomes the head when it lands at the new read pointer.
      head_n  = (wr_en && (rptr_n == wptr)) ? din : mem[rptr_n];
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         wptr     <= wptr_n;
         rptr     <= rptr_n;
         count    <= count_n;
         rd_valid <= (count_n != '0);
         if (count_n != '0)
            rd_data <= head_n;
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU retirement trace buffer: run/pass/fail supervisor with a cycle budget,
// mode-filtered capture of retired samples into a readable circular FIFO.
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int unsigned      XLEN      = 32,
   parameter int unsigned      DEPTH     = 16,
   parameter logic [XLEN-1:0]  PASS_ADR  = XLEN'(32'h64),
   parameter logic [XLEN-1:0]  PASS_DATA = XLEN'(32'h7),
   parameter int unsigned      TIMEOUT   = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     clear,
   input  logic [1:0]               mode,
   input  logic                     trace_valid,
   input  logic [XLEN-1:0]          PC,
   input  logic [XLEN-1:0]          Instr,
   input  logic [XLEN-1:0]          DataAdr,
   input  logic [XLEN-1:0]          WriteData,
   input  logic                     MemWrite,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [XLEN-1:0]          rd_pc,
   output logic [XLEN-1:0]          rd_instr,
   output logic [XLEN-1:0]          rd_adr,
   output logic [XLEN-1:0]          rd_wdata,
   output logic                     rd_memwrite,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     done,
   output logic                     pass,
   output logic [31:0]              cycles
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] adr;
      logic [XLEN-1:0] wdata;
      logic            memwrite;
   } entry_t;

   trace_state_t state, state_n;
   logic [31:0]  cycles_n;
   logic         capture, hit_adr;
   entry_t       din, rd_data;

   // Next state, cycle budget and capture decision; clear overrides everything.
   always_comb begin
      state_n  = state;
      cycles_n = cycles;
      capture  = 1'b0;
      hit_adr  = trace_valid & MemWrite & (DataAdr == PASS_ADR);
      if (clear) begin
         state_n  = ST_IDLE;
         cycles_n = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state_n  = ST_RUN;
                  cycles_n = '0;
               end
            end
            ST_RUN: begin
               capture = trace_valid & mode_selects(mode, MemWrite);
               if (cycles != '1)
                  cycles_n = cycles + 32'd1;
               if (hit_adr && (WriteData == PASS_DATA))
                  state_n = ST_PASS;
               else if (hit_adr || (cycles_n == 32'(TIMEOUT)))
                  state_n = ST_FAIL;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cycles <= '0;
         done   <= 1'b0;
         pass   <= 1'b0;
      end else begin
         state  <= state_n;
         cycles <= cycles_n;
         done   <= (state_n == ST_PASS) || (state_n == ST_FAIL);
         pass   <= (state_n == ST_PASS);
      end
   end

   assign din = '{pc: PC, instr: Instr, adr: DataAdr, wdata: WriteData, memwrite: MemWrite};

   trace_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (clear),
      .push     (capture),
      .din      (din),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .count    (count),
      .overflow (overflow)
   );

   assign rd_pc       = rd_data.pc;
   assign rd_instr    = rd_data.instr;
   assign rd_adr      = rd_data.adr;
   assign rd_wdata    = rd_data.wdata;
   assign rd_memwrite = rd_data.memwrite;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios plus a random
// run, all checked against a queue-based reference model of the trace buffer.
module tb_cpu_trace_buffer;

   localparam int unsigned M_DEPTH = 8;
   localparam int unsigned M_TO    = 64;
   localparam int unsigned T_DEPTH = 4;
   localparam int unsigned T_TO    = 8;

   logic        clk = 1'b0;
   logic        reset, start, clear, trace_valid, memwrite, rd_ready;
   logic [1:0]  mode;
   logic [31:0] pc, instr, adr, wdata;

   logic        rd_valid, rd_memwrite, overflow, done, pass;
   logic [31:0] rd_pc, rd_instr, rd_adr, rd_wdata, cycles;
   logic [3:0]  count;

   logic        t_rd_valid, t_rd_memwrite, t_overflow, t_done, t_pass;
   logic [31:0] t_rd_pc, t_rd_instr, t_rd_adr, t_rd_wdata, t_cycles;
   logic [2:0]  t_count;

   int errors = 0;
   int checks = 0;

   cpu_trace_buffer #(.XLEN(32), .DEPTH(M_DEPTH), .PASS_ADR(32'h64),
                      .PASS_DATA(32'h7), .TIMEOUT(M_TO)) dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .mode(mode),
      .trace_valid(trace_valid), .PC(pc), .Instr(instr), .DataAdr(adr),
      .WriteData(wdata), .MemWrite(memwrite), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_adr(rd_adr),
      .rd_wdata(rd_wdata), .rd_memwrite(rd_memwrite), .count(count),
      .overflow(overflow), .done(done), .pass(pass), .cycles(cycles));

   cpu_trace_buffer #(.XLEN(32), .DEPTH(T_DEPTH), .PASS_ADR(32'h64),
                      .PASS_DATA(32'h7), .TIMEOUT(T_TO)) dut_t (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .mode(mode),
      .trace_valid(trace_valid), .PC(pc), .Instr(instr), .DataAdr(adr),
      .WriteData(wdata), .MemWrite(memwrite), .rd_valid(t_rd_valid),
      .rd_ready(rd_ready), .rd_pc(t_rd_pc), .rd_instr(t_rd_instr),
      .rd_adr(t_rd_adr), .rd_wdata(t_rd_wdata), .rd_memwrite(t_rd_memwrite),
      .count(t_count), .overflow(t_overflow), .done(t_done), .pass(t_pass),
      .cycles(t_cycles));

   always #5 clk = ~clk;

   // Reference model of the main instance (DEPTH=8, TIMEOUT=64)
   typedef struct {
      logic [31:0] pc, instr, adr, wdata;
      logic        mw;
   } ent_t;

   ent_t        q[$];
   ent_t        head;
   int          m_st;   // 0 idle, 1 run, 2 pass, 3 fail
   logic        m_ovf;
   logic [31:0] m_cyc;

   task automatic model_reset();
      m_st = 0;
      q.delete();
      m_ovf = 1'b0;
      m_cyc = '0;
      head = '{pc: '0, instr: '0, adr: '0, wdata: '0, mw: 1'b0};
   endtask

   task automatic model_step();
      ent_t e;
      bit   do_pop, do_cap, hit;
      if (clear) begin
         m_st = 0;
         q.delete();
         m_ovf = 1'b0;
         m_cyc = '0;
      end else begin
         do_pop = (q.size() > 0) && rd_ready;
         do_cap = (m_st == 1) && trace_valid &&
                  ((mode == 2'd1) || ((mode == 2'd2) && memwrite));
         if (m_st == 1) begin
            hit = trace_valid && memwrite && (adr == 32'h64);
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (hit && wdata == 32'h7) m_st = 2;
            else if (hit || m_cyc == M_TO) m_st = 3;
         end else if (m_st == 0 && start) begin
            m_st = 1;
            m_cyc = '0;
         end
         if (do_pop) void'(q.pop_front());
         if (do_cap) begin
            e = '{pc: pc, instr: instr, adr: adr, wdata: wdata, mw: memwrite};
            q.push_back(e);
            if (q.size() > M_DEPTH) begin
               void'(q.pop_front());
               m_ovf = 1'b1;
            end
         end
      end
      if (q.size() > 0) head = q[0];
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_adr();
      return $urandom | 32'h0000_1000;
   endfunction

   task automatic set_sample(input bit v, input bit mw, input logic [31:0] a,
                             input logic [31:0] d);
      trace_valid = v;
      memwrite = mw;
      pc = $urandom;
      instr = $urandom;
      adr = a;
      wdata = d;
   endtask

   task automatic restart(input logic [1:0] m);
      trace_valid = 1'b0;
      rd_ready = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      mode = m;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; clear = 1'b0; mode = 2'd0; trace_valid = 1'b0;
      memwrite = 1'b0; rd_ready = 1'b0; pc = '0; instr = '0; adr = '0; wdata = '0;
      model_reset();
      #12;
      checks++;
      if ({rd_valid, overflow, done, pass} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000", {rd_valid, overflow, done, pass});
      end
      checks++;
      if (count !== 4'd0 || cycles !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters got count=%0d cycles=%0d exp 0/0", count, cycles);
      end
      checks++;
      if ({rd_pc, rd_instr, rd_adr, rd_wdata, rd_memwrite} !== '0) begin
         errors++;
         $display("FAIL reset_rd got pc=%h instr=%h exp 0", rd_pc, rd_instr);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_capture_all();
      logic [31:0] pcs[5];
      restart(2'd1);
      for (int i = 0; i < 5; i++) begin
         set_sample(1'b1, 1'b0, rand_adr(), $urandom);
         pcs[i] = pc;
         step();
      end
      trace_valid = 1'b0;
      checks++;
      if (count !== 4'd5) begin
         errors++;
         $display("FAIL capture_count got %0d exp 5", count);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_pc !== pcs[i]) begin
            errors++;
            $display("FAIL capture_pop%0d got v=%b pc=%h exp v=1 pc=%h", i, rd_valid, rd_pc, pcs[i]);
         end
         step();
      end
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || count !== 4'd0 || rd_pc !== pcs[4]) begin
         errors++;
         $display("FAIL capture_drained got v=%b count=%0d pc=%h exp v=0 count=0 pc=%h",
                  rd_valid, count, rd_pc, pcs[4]);
      end
   endtask

   task automatic test_overflow_stores();
      logic [31:0] spc[6];
      restart(2'd2);
      for (int i = 0; i < 6; i++) begin
         set_sample(1'b1, 1'b1, rand_adr(), $urandom);
         spc[i] = pc;
         step();
      end
      set_sample(1'b1, 1'b0, rand_adr(), $urandom);
      step();
      trace_valid = 1'b0;
      checks++;
      if (t_count !== 3'd4 || t_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_small got count=%0d ovf=%b exp 4/1", t_count, t_overflow);
      end
      checks++;
      if (t_rd_pc !== spc[2] || t_rd_memwrite !== 1'b1) begin
         errors++;
         $display("FAIL ovf_head got pc=%h mw=%b exp pc=%h mw=1", t_rd_pc, t_rd_memwrite, spc[2]);
      end
      checks++;
      if (count !== 4'd6 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_big got count=%0d ovf=%b exp 6/0", count, overflow);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++;
      if (t_rd_pc !== spc[3] || t_count !== 3'd3 || rd_pc !== spc[1]) begin
         errors++;
         $display("FAIL ovf_pop got t_pc=%h t_count=%0d pc=%h exp %h 3 %h",
                  t_rd_pc, t_count, rd_pc, spc[3], spc[1]);
      end
   endtask

   task automatic test_full_capture_pop();
      restart(2'd1);
      for (int i = 0; i < 8; i++) begin
         set_sample(1'b1, 1'b0, rand_adr(), $urandom);
         step();
      end
      checks++;
      if (count !== 4'd8 || overflow !== 1'b0 || rd_pc !== head.pc) begin
         errors++;
         $display("FAIL full_fill got count=%0d ovf=%b pc=%h exp 8/0 pc=%h", count, overflow, rd_pc, head.pc);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_sample(1'b1, 1'b0, rand_adr(), $urandom);
         step();
         checks++;
         if (count !== 4'd8 || overflow !== 1'b0 || rd_pc !== head.pc) begin
            errors++;
            $display("FAIL full_cap_pop%0d got count=%0d ovf=%b pc=%h exp 8/0 pc=%h",
                     i, count, overflow, rd_pc, head.pc);
         end
      end
      rd_ready = 1'b0;
      set_sample(1'b1, 1'b0, rand_adr(), $urandom);
      step();
      trace_valid = 1'b0;
      checks++;
      if (count !== 4'd8 || overflow !== 1'b1 || rd_pc !== head.pc) begin
         errors++;
         $display("FAIL full_overwrite got count=%0d ovf=%b pc=%h exp 8/1 pc=%h", count, overflow, rd_pc, head.pc);
      end
   endtask

   task automatic test_pass_store();
      logic [3:0] nc;
      restart(2'd2);
      for (int i = 1; i <= 9; i++) begin
         set_sample(1'($urandom % 2), 1'($urandom % 2), rand_adr(), $urandom);
         step();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL pass_early%0d got done=%b exp 0", i, done);
         end
      end
      set_sample(1'b1, 1'b1, 32'h64, 32'h7);
      step();
      trace_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || cycles !== 32'd10) begin
         errors++;
         $display("FAIL pass_hit got done=%b pass=%b cycles=%0d exp 1/1/10", done, pass, cycles);
      end
      checks++;
      if (32'(count) !== 32'(q.size()) || rd_pc !== head.pc) begin
         errors++;
         $display("FAIL pass_captured got count=%0d pc=%h exp %0d pc=%h", count, rd_pc, q.size(), head.pc);
      end
      nc = count;
      for (int i = 0; i < 3; i++) begin
         set_sample(1'b1, 1'b1, rand_adr(), $urandom);
         step();
      end
      trace_valid = 1'b0;
      checks++;
      if (count !== nc || cycles !== 32'd10 || done !== 1'b1) begin
         errors++;
         $display("FAIL pass_frozen got count=%0d cycles=%0d done=%b exp %0d/10/1", count, cycles, done, nc);
      end
   endtask

   task automatic test_fail_store();
      restart(2'd1);
      for (int i = 0; i < 3; i++) begin
         set_sample(1'b1, 1'b0, rand_adr(), $urandom);
         step();
      end
      set_sample(1'b1, 1'b1, 32'h64, 32'h5);
      step();
      trace_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || cycles !== 32'd4) begin
         errors++;
         $display("FAIL fail_store got done=%b pass=%b cycles=%0d exp 1/0/4", done, pass, cycles);
      end
   endtask

   task automatic test_timeout();
      restart(2'd1);
      for (int i = 0; i < 7; i++) step();
      checks++;
      if (t_done !== 1'b0 || t_cycles !== 32'd7) begin
         errors++;
         $display("FAIL timeout_before got done=%b cycles=%0d exp 0/7", t_done, t_cycles);
      end
      step();
      checks++;
      if (t_done !== 1'b1 || t_pass !== 1'b0 || t_cycles !== 32'd8) begin
         errors++;
         $display("FAIL timeout_hit got done=%b pass=%b cycles=%0d exp 1/0/8", t_done, t_pass, t_cycles);
      end
      step();
      checks++;
      if (t_cycles !== 32'd8 || done !== 1'b0 || cycles !== 32'd9) begin
         errors++;
         $display("FAIL timeout_hold got t_cycles=%0d done=%b cycles=%0d exp 8/0/9", t_cycles, done, cycles);
      end
      restart(2'd0);
      for (int i = 0; i < 7; i++) step();
      set_sample(1'b1, 1'b1, 32'h64, 32'h7);
      step();
      trace_valid = 1'b0;
      checks++;
      if (t_done !== 1'b1 || t_pass !== 1'b1 || t_cycles !== 32'd8) begin
         errors++;
         $display("FAIL timeout_tie got done=%b pass=%b cycles=%0d exp 1/1/8", t_done, t_pass, t_cycles);
      end
   endtask

   task automatic test_reset_mid_run();
      restart(2'd1);
      for (int i = 0; i < 3; i++) begin
         set_sample(1'b1, 1'b0, rand_adr(), $urandom);
         step();
      end
      checks++;
      if (count !== 4'd3) begin
         errors++;
         $display("FAIL midrun_count got %0d exp 3", count);
      end
      set_sample(1'b1, 1'b0, rand_adr(), $urandom);
      #3 reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if (count !== 4'd0 || rd_valid !== 1'b0 || rd_pc !== 32'd0 || cycles !== 32'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midrun_abort got count=%0d v=%b pc=%h cycles=%0d done=%b exp all 0",
                  count, rd_valid, rd_pc, cycles, done);
      end
      #2 reset = 1'b1;
      start = 1'b1;
      clear = 1'b1;
      step();
      start = 1'b0;
      clear = 1'b0;
      checks++;
      if ({rd_valid, overflow, done, pass} !== 4'b0 || count !== 4'd0 || cycles !== 32'd0 ||
          rd_pc !== 32'd0 || rd_wdata !== 32'd0) begin
         errors++;
         $display("FAIL start_clear got v=%b ovf=%b done=%b pass=%b count=%0d cycles=%0d pc=%h exp all 0",
                  rd_valid, overflow, done, pass, count, cycles, rd_pc);
      end
      step();
      step();
      trace_valid = 1'b0;
      checks++;
      if (count !== 4'd0 || cycles !== 32'd0) begin
         errors++;
         $display("FAIL still_idle got count=%0d cycles=%0d exp 0/0", count, cycles);
      end
   endtask

   task automatic test_random();
      restart(2'($urandom % 4));
      for (int n = 0; n < 400; n++) begin
         clear = ($urandom % 40) == 0;
         start = ($urandom % 8) == 0;
         mode = 2'($urandom % 4);
         set_sample(1'($urandom % 2), 1'($urandom % 2),
                    (($urandom % 12) == 0) ? 32'h64 : rand_adr(),
                    (($urandom % 2) == 0) ? 32'h7 : 32'($urandom % 8));
         rd_ready = 1'($urandom % 2);
         step();
         checks++;
         if (32'(count) !== 32'(q.size()) || rd_valid !== (q.size() > 0) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand_fifo%0d got count=%0d v=%b ovf=%b exp %0d/%b/%b",
                     n, count, rd_valid, overflow, q.size(), q.size() > 0, m_ovf);
         end
         checks++;
         if ({rd_pc, rd_instr, rd_adr, rd_wdata, rd_memwrite} !==
             {head.pc, head.instr, head.adr, head.wdata, head.mw}) begin
            errors++;
            $display("FAIL rand_head%0d got pc=%h adr=%h exp pc=%h adr=%h", n, rd_pc, rd_adr, head.pc, head.adr);
         end
         checks++;
         if (done !== (m_st >= 2) || pass !== (m_st == 2) || cycles !== m_cyc) begin
            errors++;
            $display("FAIL rand_state%0d got done=%b pass=%b cycles=%0d exp %b/%b/%0d",
                     n, done, pass, cycles, m_st >= 2, m_st == 2, m_cyc);
         end
      end
      clear = 1'b0;
      start = 1'b0;
      trace_valid = 1'b0;
      rd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_capture_all();
      test_overflow_stores();
      test_full_capture_pop();
      test_pass_store();
      test_fail_store();
      test_timeout();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32: width of PC, Instr, DataAdr, WriteData fields.
REQ-002 Parameter DEPTH, default 16: trace entries held; power of two, >= 2.
REQ-003 Parameter PASS_ADR, default 32'h64: store address that ends the program.
REQ-004 Parameter PASS_DATA, default 32'h7: store data that signals pass.
REQ-005 Parameter TIMEOUT, default 1024: RUN cycles allowed before fail; >= 1.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse; IDLE->RUN.
REQ-010 clear  in  1  synchronous flush; any state->IDLE, buffer emptied.
REQ-011 mode  in  2  capture mode: 0 off, 1 all samples, 2 stores only (MemWrite=1); 3 treated as 0.
REQ-012 trace_valid  in  1  sample below is a retired instruction this cycle.
REQ-013 PC, Instr, DataAdr, WriteData  in  XLEN each  retired-instruction sample.
REQ-014 MemWrite  in  1  sample performs a store.
REQ-015 rd_valid  out  1  oldest entry available on rd_* outputs.
REQ-016 rd_ready  in  1  consumer accepts entry when rd_valid=1.
REQ-017 rd_pc, rd_instr, rd_adr, rd_wdata  out  XLEN each; rd_memwrite  out  1  oldest entry fields.
REQ-018 count  out  $clog2(DEPTH)+1  entries held.
REQ-019 overflow  out  1  sticky: an entry was overwritten.
REQ-020 done  out  1  state is PASS or FAIL; pass  out  1  state is PASS.
REQ-021 cycles  out  32  RUN cycles elapsed, saturating at 2^32-1.

Function
REQ-022 States IDLE, RUN, PASS, FAIL; IDLE->RUN on start; clear wins over start and all other events.
REQ-023 In RUN, sample captured when trace_valid=1 and mode selects it (1: all; 2: MemWrite=1); no capture outside RUN.
REQ-024 RUN->PASS when trace_valid & MemWrite & DataAdr==PASS_ADR & WriteData==PASS_DATA; that sample is captured if mode selects it.
REQ-025 RUN->FAIL when trace_valid & MemWrite & DataAdr==PASS_ADR & WriteData!=PASS_DATA, or cycles reaches TIMEOUT with no pass.
REQ-026 Pass/fail store and timeout in same cycle: PASS wins.
REQ-027 cycles increments each RUN cycle, holds in PASS/FAIL, zeroes on clear and on IDLE->RUN.
REQ-028 Buffer is a circular FIFO; capture latency 1 cycle (entry visible on rd_* the cycle after capture if buffer was empty).
REQ-029 Pop occurs on rd_valid & rd_ready; rd_* show next entry following cycle.
REQ-030 Capture when full and no pop: oldest entry overwritten, read pointer advances, count stays DEPTH, overflow set.
REQ-031 Capture and pop same cycle: count unchanged, no overflow, even when full.
REQ-032 Empty: rd_valid=0, rd_* hold last value, pop ignored; pointers wrap modulo DEPTH.
REQ-033 Readout allowed in every state, including PASS/FAIL after capture stops.

Reset
REQ-034 On reset low: state IDLE, pointers and count 0, overflow 0, cycles 0, done 0, pass 0, rd_valid 0, rd_* 0.
REQ-035 Reset asserted mid-RUN aborts immediately; no partial entry retained.
REQ-036 Storage array needs no reset; only pointers, count and flags are reset.

Structure
REQ-037 Shared package cpu_trace_pkg SHALL hold state enum trace_state_t, mode constants, and packed struct trace_entry_t {pc, instr, adr, wdata, memwrite}.
REQ-038 One sub-module trace_fifo (parametrised DEPTH, entry type) SHALL implement storage, pointers, overwrite-on-full; FSM, counters and matching stay in top.

Verification
REQ-039 start, mode=1, 5 valid non-store samples -> count=5, rd_pc pops in order, rd_valid falls after 5th pop.
REQ-040 mode=2, DEPTH=4, 6 stores, rd_ready=0 -> count=4, overflow=1, first pop shows 3rd store.
REQ-041 Store DataAdr=0x64 WriteData=7 at cycle 10 -> next cycle done=1, pass=1, cycles=10, later samples not captured.
REQ-042 Store DataAdr=0x64 WriteData=5 -> done=1, pass=0; TIMEOUT=8, no stores -> done=1, pass=0 after 8 RUN cycles.
REQ-043 Full buffer, capture+pop same cycle -> count stays DEPTH, overflow stays 0.
REQ-044 reset low mid-RUN with count=3, then start and clear same cycle -> all outputs at reset values, state IDLE.
